ram_sync: RTL and testbench



---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_sync.sv | 60 ++++++
 tb/tb_ram_sync.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Purpose : shared default geometry and word/address types for ram_sync.
// Contents: ADDR_WIDTH_DEF / DATA_WIDTH_DEF default constants and the
//           addr_t / data_t typedefs derived from them.
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage : ram_pkg

// File: rtl/ram_sync.sv
// ---------------------------------------------------------------------------
// ram_sync
// Purpose : single-port synchronous RAM, 2**ADDR_WIDTH words of DATA_WIDTH
//           bits, synchronous write and registered read (1-cycle latency).
//           Default mode is read-first: a write and a read of the same
//           address on one edge returns the old contents.
// Build option:
//   RAM_WRITE_THROUGH_EN  when defined, the RAM is write-first: a write
//                         edge also loads the write data into or_data.
// Ports:
//   i_clk    in   1           clock, rising edge
//   i_rst_n  in   1           synchronous active-low reset (clears or_data,
//                             blocks writes; array contents untouched)
//   i_addr   in   ADDR_WIDTH  read/write address
//   i_data   in   DATA_WIDTH  write data
//   i_we     in   1           write enable, active high
//   or_data  out  DATA_WIDTH  registered read data
// ---------------------------------------------------------------------------
module ram_sync
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_we,
  output logic [DATA_WIDTH-1:0] or_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Plain array with no reset so synthesis can map it onto block RAM.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // ---- stage p0 -> p1: array write ----
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_we) begin
      mem[i_addr] <= i_data;
    end
  end

  // ---- stage p0 -> p1: registered read port ----
  // The read samples the array before this edge's write lands, which gives
  // read-first ordering without any explicit bypass.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      or_data <= '0;
`ifdef RAM_WRITE_THROUGH_EN
    end else if (i_we) begin
      or_data <= i_data;
`endif
    end else begin
      or_data <= mem[i_addr];
    end
  end

endmodule : ram_sync

// File: tb/tb_ram_sync.sv
// ---------------------------------------------------------------------------
// tb_ram_sync
// Purpose : self-checking bench for ram_sync. A driver issues one operation
//           per clock and pushes the expected or_data for that edge into a
//           scoreboard queue; a monitor pops one entry after every rising
//           edge and compares it with or_data. The reference is a sparse
//           associative-array memory; words never written are "don't care".
// Honours RAM_WRITE_THROUGH_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_ram_sync;

  localparam int AW = 8;
  localparam int DW = 8;

`ifdef RAM_WRITE_THROUGH_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          we;
  logic [DW-1:0] rdata;

  ram_sync #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_addr (addr),
    .i_data (data),
    .i_we   (we),
    .or_data(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            care;
    logic [DW-1:0] val;
    int            id;
    int            addr;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[int];
  int            checks = 0;
  int            errors = 0;
  int            n_ops  = 0;

  // One operation: drive on the falling edge, predict what or_data must hold
  // after the next rising edge, then update the reference memory.
  task automatic op(input bit r, input int a, input int d, input bit w);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    addr  = a[AW-1:0];
    data  = d[DW-1:0];
    we    = w;
    e.care = 1'b1;
    e.id   = n_ops;
    e.addr = a;
    e.val  = '0;
    n_ops++;
    if (!r) begin
      e.val = '0;
    end else begin
      if (w && WRITE_FIRST) begin
        e.val = d[DW-1:0];
      end else if (model.exists(a)) begin
        e.val = model[a];
      end else begin
        e.care = 1'b0;
      end
      if (w) model[a] = d[DW-1:0];
    end
    sb.push_back(e);
  endtask

  // Monitor: every rising edge produces one output word.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.care) begin
          checks++;
          if (rdata !== e.val) begin
            errors++;
            $display("FAIL op%0d addr=%0d or_data: got %0d expected %0d",
                     e.id, e.addr, rdata, e.val);
          end
        end
      end
    end
  end

  initial begin : driver
    int a;
    rst_n = 1'b0;
    addr  = '0;
    data  = '0;
    we    = 1'b0;

    // Reset for two edges.
    op(0, 0, 8'hA5, 1);
    op(0, 0, 8'h5A, 1);

    // Write/read: two edges each.
    op(1, 3, 11, 1);
    op(1, 3, 11, 0);
    op(1, 6, 22, 1);
    op(1, 6, 22, 0);

    // Write-disable: memory must keep 11 and 22.
    op(1, 3, 33, 0);
    op(1, 3, 33, 0);
    op(1, 6, 44, 0);
    op(1, 6, 44, 0);

    // Burst write then burst read.
    for (int i = 1; i <= 9; i++) op(1, i, i * 10, 1);
    for (int i = 1; i <= 9; i++) op(1, i, 8'hFF, 0);
    op(1, 0, 0, 0);

    // Same-address read/write: old data (read-first) or new (write-first).
    op(1, 5, 7, 1);
    op(1, 5, 9, 1);
    op(1, 5, 9, 0);
    op(1, 5, 9, 0);

    // Reset mid-run clears only the output register.
    op(0, 4, 123, 1);
    op(1, 4, 0, 0);
    op(1, 4, 0, 0);
    op(1, 9, 0, 0);

    // Extreme addresses.
    op(1, 0, 8'hFF, 1);
    op(1, 255, 8'h81, 1);
    op(1, 0, 0, 0);
    op(1, 255, 0, 0);

    // Randomised traffic, biased to a small window so reads hit written words.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 255));
      else                           a = int'($urandom_range(0, 15));
      op(($urandom_range(0, 29) != 0), a, int'($urandom_range(0, 255)),
         $urandom_range(0, 1) == 1);
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_sync
